// File: rtl/ascon_pack.sv
// Shared Ascon datapath types and XOR-end mode encodings used by the
// post-permutation output stage and its combinational XOR helper.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam logic [1:0] XE_NONE = 2'b00;
  localparam logic [1:0] XE_KEY  = 2'b01;
  localparam logic [1:0] XE_DSEP = 2'b10;

  localparam logic [63:0] DSEP_BIT = 64'h1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_TAG_PEND = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/xor_end.sv
// Combinational end-of-permutation XOR: key into S3/S4 or the domain
// separation bit into S4. Reserved mode 2'b11 passes the state through.
module xor_end
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [127:0] key_i,
  input  logic [1:0]  mode_i,
  output type_state   state_o
);

  always_comb begin
    state_o = state_i;
    case (mode_i)
      XE_KEY: begin
        state_o[3] = state_i[3] ^ key_i[63:0];
        state_o[4] = state_i[4] ^ key_i[127:64];
      end
      XE_DSEP: state_o[4] = state_i[4] ^ DSEP_BIT;
      default: state_o = state_i;
    endcase
  end

endmodule

// File: rtl/xor_end_out.sv
// Registered output stage after the Ascon permutation: applies the XOR-end,
// holds the state, and presents the final tag on a valid/ready handshake.
module xor_end_out
  import ascon_pack::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             valid_i,
  input  type_state        state_i,
  input  logic [1:0]       bypass_xor_end_i,
  input  logic [127:0]     key_i,
  input  logic             last_i,
  input  logic             decrypt_i,
  input  logic [127:0]     tag_ref_i,
  input  logic             tag_ready_i,
  output type_state        state_o,
  output logic             state_valid_o,
  output logic [127:0]     tag_o,
  output logic             tag_valid_o,
  output logic             tag_ok_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] block_cnt_o
);

  fsm_state_t       r_fsm;
  fsm_state_t       w_fsm_next;
  type_state        r_state;
  type_state        w_state_xe;
  logic             r_state_valid;
  logic [127:0]     r_tag;
  logic             r_tag_ok;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic [127:0]     w_tag;

  xor_end u_xor_end (
    .state_i (state_i),
    .key_i   (key_i),
    .mode_i  (bypass_xor_end_i),
    .state_o (w_state_xe)
  );

  assign w_tag = {w_state_xe[4], w_state_xe[3]};

  // New results are only taken in IDLE; a pending tag blocks the input.
  assign w_accept = valid_i && (r_fsm == ST_IDLE);

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      ST_IDLE:     if (w_accept && last_i) w_fsm_next = ST_TAG_PEND;
      ST_TAG_PEND: if (tag_ready_i)        w_fsm_next = ST_IDLE;
      default:     w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_fsm         <= ST_IDLE;
      r_state       <= '0;
      r_state_valid <= 1'b0;
      r_tag         <= '0;
      r_tag_ok      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_fsm         <= w_fsm_next;
      r_state_valid <= w_accept;
      if (w_accept) begin
        r_state <= w_state_xe;
        r_cnt   <= r_cnt + 1'b1;
        if (last_i) begin
          r_tag    <= w_tag;
          r_tag_ok <= decrypt_i && (w_tag == tag_ref_i);
        end
      end
    end
  end

  assign state_o       = r_state;
  assign state_valid_o = r_state_valid;
  assign tag_o         = r_tag;
  assign tag_valid_o   = (r_fsm == ST_TAG_PEND);
  assign tag_ok_o      = r_tag_ok;
  assign busy_o        = (r_fsm == ST_TAG_PEND);
  assign block_cnt_o   = r_cnt;

endmodule

// File: tb/tb_xor_end_out.sv
// Directed bench for xor_end_out: reset, key and domain-separation XOR,
// tag handshake, decrypt compare and reset during a pending tag.
module tb_xor_end_out;
  import ascon_pack::*;

  localparam logic [127:0] KEY = 128'h0011223344556677_8899AABBCCDDEEFF;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic         valid_i;
  type_state    state_i;
  logic [1:0]   bypass_xor_end_i;
  logic [127:0] key_i;
  logic         last_i;
  logic         decrypt_i;
  logic [127:0] tag_ref_i;
  logic         tag_ready_i;
  type_state    state_o;
  logic         state_valid_o;
  logic [127:0] tag_o;
  logic         tag_valid_o;
  logic         tag_ok_o;
  logic         busy_o;
  logic [7:0]   block_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock_i = ~clock_i;

  xor_end_out #(.CNT_W(8)) dut (
    .clock_i          (clock_i),
    .resetb_i         (resetb_i),
    .valid_i          (valid_i),
    .state_i          (state_i),
    .bypass_xor_end_i (bypass_xor_end_i),
    .key_i            (key_i),
    .last_i           (last_i),
    .decrypt_i        (decrypt_i),
    .tag_ref_i        (tag_ref_i),
    .tag_ready_i      (tag_ready_i),
    .state_o          (state_o),
    .state_valid_o    (state_valid_o),
    .tag_o            (tag_o),
    .tag_valid_o      (tag_valid_o),
    .tag_ok_o         (tag_ok_o),
    .busy_o           (busy_o),
    .block_cnt_o      (block_cnt_o)
  );

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; last_i = 1'b0; decrypt_i = 1'b0; tag_ready_i = 1'b0;
    state_i = '0; bypass_xor_end_i = XE_NONE; key_i = KEY; tag_ref_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetb_i = 1'b0; valid_i = 1'b1; last_i = 1'b1;
    state_i = {5{64'hA5A5A5A5A5A5A5A5}}; bypass_xor_end_i = XE_KEY;
    step(); step();
    n_cmp++; if (state_o !== '0) begin n_err++; $display("FAIL reset_state: got %h want 0", state_o); end
    n_cmp++; if (tag_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_tag_valid: got %b want 0", tag_valid_o); end
    n_cmp++; if (block_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", block_cnt_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (tag_o !== '0 || state_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_tag: tag %h sv %b want 0/0", tag_o, state_valid_o); end
    idle_inputs();
    resetb_i = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_key_xor();
    idle_inputs();
    bypass_xor_end_i = XE_KEY; valid_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (state_o[3] !== 64'h8899AABBCCDDEEFF) begin n_err++; $display("FAIL key_s3: got %h want 8899aabbccddeeff", state_o[3]); end
    n_cmp++; if (state_o[4] !== 64'h0011223344556677) begin n_err++; $display("FAIL key_s4: got %h want 0011223344556677", state_o[4]); end
    n_cmp++; if (state_o[0] !== 64'h0 || state_o[1] !== 64'h0 || state_o[2] !== 64'h0) begin n_err++; $display("FAIL key_s012: got %h %h %h want 0", state_o[0], state_o[1], state_o[2]); end
    n_cmp++; if (state_valid_o !== 1'b1) begin n_err++; $display("FAIL key_sv: got %b want 1", state_valid_o); end
    n_cmp++; if (block_cnt_o !== 8'd1) begin n_err++; $display("FAIL key_cnt: got %0d want 1", block_cnt_o); end
    step();
    n_cmp++; if (state_valid_o !== 1'b0) begin n_err++; $display("FAIL key_sv_pulse: got %b want 0", state_valid_o); end
    n_cmp++; if (state_o[3] !== 64'h8899AABBCCDDEEFF) begin n_err++; $display("FAIL key_hold: got %h want 8899aabbccddeeff", state_o[3]); end
    $display("test_key_xor done");
  endtask

  task automatic test_dsep();
    idle_inputs();
    state_i[4] = 64'hFFFFFFFFFFFFFFFF; bypass_xor_end_i = XE_DSEP; valid_i = 1'b1;
    step();
    bypass_xor_end_i = 2'b11;
    n_cmp++; if (state_o[4] !== 64'hFFFFFFFFFFFFFFFE) begin n_err++; $display("FAIL dsep_s4: got %h want fffffffffffffffe", state_o[4]); end
    n_cmp++; if (state_o[3] !== 64'h0) begin n_err++; $display("FAIL dsep_s3: got %h want 0", state_o[3]); end
    step();
    idle_inputs();
    n_cmp++; if (state_o[4] !== 64'hFFFFFFFFFFFFFFFF) begin n_err++; $display("FAIL mode11_s4: got %h want ffffffffffffffff", state_o[4]); end
    n_cmp++; if (block_cnt_o !== 8'd3 || state_valid_o !== 1'b1) begin n_err++; $display("FAIL back_to_back: cnt %0d sv %b want 3/1", block_cnt_o, state_valid_o); end
    step();
    $display("test_dsep done");
  endtask

  task automatic test_encrypt_tag();
    idle_inputs();
    bypass_xor_end_i = XE_KEY; last_i = 1'b1; valid_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (tag_o !== KEY) begin n_err++; $display("FAIL enc_tag: got %h want %h", tag_o, KEY); end
    n_cmp++; if (tag_ok_o !== 1'b0) begin n_err++; $display("FAIL enc_tag_ok: got %b want 0", tag_ok_o); end
    n_cmp++; if (block_cnt_o !== 8'd4) begin n_err++; $display("FAIL enc_cnt: got %0d want 4", block_cnt_o); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (tag_valid_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("FAIL enc_hold%0d: tv %b busy %b want 1/1", c, tag_valid_o, busy_o); end
      valid_i = (c == 0); state_i[0] = 64'h5; bypass_xor_end_i = XE_NONE;
      step();
      idle_inputs();
    end
    n_cmp++; if (state_o[0] !== 64'h0 || block_cnt_o !== 8'd4 || state_valid_o !== 1'b0) begin n_err++; $display("FAIL enc_ignore: s0 %h cnt %0d sv %b want 0/4/0", state_o[0], block_cnt_o, state_valid_o); end
    n_cmp++; if (tag_valid_o !== 1'b1 || tag_o !== KEY) begin n_err++; $display("FAIL enc_stable: tv %b tag %h", tag_valid_o, tag_o); end
    tag_ready_i = 1'b1;
    step();
    tag_ready_i = 1'b0;
    n_cmp++; if (tag_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL enc_release: tv %b busy %b want 0/0", tag_valid_o, busy_o); end
    $display("test_encrypt_tag done");
  endtask

  task automatic test_decrypt(input logic [127:0] ref_tag, input logic exp_ok, input logic [7:0] exp_cnt);
    idle_inputs();
    bypass_xor_end_i = XE_KEY; last_i = 1'b1; decrypt_i = 1'b1; tag_ref_i = ref_tag; valid_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (tag_ok_o !== exp_ok) begin n_err++; $display("FAIL dec_tag_ok: got %b want %b", tag_ok_o, exp_ok); end
    n_cmp++; if (tag_valid_o !== 1'b1 || block_cnt_o !== exp_cnt) begin n_err++; $display("FAIL dec_state: tv %b cnt %0d want 1/%0d", tag_valid_o, block_cnt_o, exp_cnt); end
    tag_ready_i = 1'b1;
    step();
    tag_ready_i = 1'b0;
    $display("test_decrypt ref=%h done", ref_tag);
  endtask

  task automatic test_reset_tag_pend();
    idle_inputs();
    bypass_xor_end_i = XE_KEY; last_i = 1'b1; valid_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (tag_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_pend_pre: tv %b want 1", tag_valid_o); end
    resetb_i = 1'b0;
    step();
    resetb_i = 1'b1;
    n_cmp++; if (tag_valid_o !== 1'b0 || tag_o !== '0 || busy_o !== 1'b0 || block_cnt_o !== 8'd0) begin n_err++; $display("FAIL rst_pend: tv %b tag %h busy %b cnt %0d want 0", tag_valid_o, tag_o, busy_o, block_cnt_o); end
    state_i[2] = 64'h0123456789ABCDEF; valid_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (block_cnt_o !== 8'd1 || state_o[2] !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL rst_pend_accept: cnt %0d s2 %h want 1/0123456789abcdef", block_cnt_o, state_o[2]); end
    $display("test_reset_tag_pend done");
  endtask

  initial begin
    idle_inputs();
    resetb_i = 1'b0;
    test_reset();
    test_key_xor();
    test_dsep();
    test_encrypt_tag();
    test_decrypt(KEY, 1'b1, 8'd5);
    test_decrypt(KEY ^ 128'h1, 1'b0, 8'd6);
    test_reset_tag_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
